// File: rtl/cpu_pkg.sv
// Shared register-file types: register id / data widths and the write-request record.
package cpu_pkg;

    localparam int REG_ID_W = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;

    typedef struct packed {
        logic [REG_ID_W-1:0] reg_id;
        logic [DATA_W-1:0]   data;
    } wr_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ID_W-1:0] r);
        reg_onehot    = '0;
        reg_onehot[r] = 1'b1;
    endfunction

endpackage

// File: rtl/wr_fifo.sv
// Circular buffer of load-return writes; exposes per-slot valid bits and reg ids
// so the arbiter can do hazard compares against every buffered entry.
module wr_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  wr_req_t                   din_i,
    output wr_req_t                   head_o,
    output logic [CNT_W-1:0]          count_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [DEPTH-1:0]          vld_o,
    output logic [DEPTH*REG_ID_W-1:0] ids_o
);

    wr_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   vld_q, vld_d;
    logic               push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign vld_o   = vld_q;
    assign head_o  = mem_q[rptr_q];

    for (genvar i = 0; i < DEPTH; i++) begin : g_ids
        assign ids_o[i*REG_ID_W +: REG_ID_W] = mem_q[i].reg_id;
    end

    // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
    always_comb begin
        push_ok = push_i && (!full_o || pop_i);
        pop_ok  = pop_i && !empty_o;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        vld_d   = vld_q;
        if (pop_ok) begin
            rptr_d        = rptr_q + PTR_W'(1);
            vld_d[rptr_q] = 1'b0;
        end
        if (push_ok) begin
            wptr_d        = wptr_q + PTR_W'(1);
            vld_d[wptr_q] = 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            mem_q[wptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the register file's single write port between ALU writeback (A)
// and buffered load returns (B), with hazard ordering and a pending-register mask.
module regfile_wport_arbiter
    import cpu_pkg::*;
#(
    parameter  int FIFO_DEPTH   = 4,
    parameter  int STARVE_LIMIT = 3,
    parameter  int DROP_R0      = 1,
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [REG_ID_W-1:0] a_reg,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    input  logic [REG_ID_W-1:0] b_reg,
    input  logic [DATA_W-1:0]   b_data,
    output logic                WriteReg,
    output logic [REG_ID_W-1:0] DstReg,
    output logic [DATA_W-1:0]   DstData,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W-1:0]    fifo_count,
    output logic                overflow
);

    wr_req_t                        fifo_head;
    logic [FIFO_DEPTH-1:0]          fifo_vld;
    logic [FIFO_DEPTH*REG_ID_W-1:0] fifo_ids;
    logic                           fifo_full, fifo_empty;

    logic       a_conflict, fifo_ne, starve, grant_a, grant_b, granted;
    wr_req_t    sel;
    logic [3:0] starve_q, starve_d;
    logic       overflow_q, overflow_d;
    logic       wr_en_q, wr_en_d;
    wr_req_t    dst_q, dst_d;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        sat_inc4 = (v == 4'hF) ? v : v + 4'd1;
    endfunction

    wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (b_valid),
        .pop_i   (grant_b),
        .din_i   ({b_reg, b_data}),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .vld_o   (fifo_vld),
        .ids_o   (fifo_ids)
    );

    // A same-cycle load return to A's register counts as older, so A must wait.
    always_comb begin
        a_conflict = b_valid && (b_reg == a_reg);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_ids[i*REG_ID_W +: REG_ID_W] == a_reg)) begin
                a_conflict = 1'b1;
            end
        end
        fifo_ne = !fifo_empty;
        starve  = (starve_q >= 4'(STARVE_LIMIT));
        grant_b = !rst && fifo_ne && (!a_valid || starve || a_conflict);
        grant_a = !rst && !grant_b && a_valid && !a_conflict;
        granted = grant_a || grant_b;
        a_ready = grant_a;
    end

    always_comb begin
        sel        = grant_b ? fifo_head : {a_reg, a_data};
        wr_en_d    = granted && !((DROP_R0 != 0) && (sel.reg_id == '0));
        dst_d      = granted ? sel : dst_q;
        overflow_d = overflow_q || (b_valid && fifo_full && !grant_b);
        starve_d   = starve_q;
        if (grant_b || !fifo_ne) begin
            starve_d = 4'd0;
        end else if (grant_a) begin
            starve_d = sat_inc4(starve_q);
        end
    end

    // Output stage: grant registers onto the write port one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            dst_q      <= '0;
            starve_q   <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_en_q    <= wr_en_d;
            dst_q      <= dst_d;
            starve_q   <= starve_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i]) begin
                pending = pending | reg_onehot(fifo_ids[i*REG_ID_W +: REG_ID_W]);
            end
        end
        if (wr_en_q) begin
            pending = pending | reg_onehot(dst_q.reg_id);
        end
    end

    assign WriteReg = wr_en_q;
    assign DstReg   = dst_q.reg_id;
    assign DstData  = dst_q.data;
    assign overflow = overflow_q;

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port (WriteReg/DstReg/DstData) between two producers.
  - Requester A: pipeline writeback (ALU results), with a valid/ready handshake.
  - Requester B: memory load return. It is never back-pressured and is buffered in an internal FIFO.
- Output stage is registered.
- Exports a per-register pending mask so issue/hazard logic can stall RAW/WAW consumers.

Parameters:
- FIFO_DEPTH, 4, number of load-return entries buffered (power of 2, 2..8).
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may lose to requester A before it is forced to win (1..15).
- DROP_R0, 1, when 1, writes targeting register 0 are accepted but never asserted on the write port.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a_valid  in  1  writeback request valid
- a_ready  out  1  writeback request accepted this cycle (combinational)
- a_reg  in  4  writeback destination register
- a_data  in  16  writeback data
- b_valid  in  1  load-return write valid (always pushed)
- b_reg  in  4  load-return destination register
- b_data  in  16  load-return data
- WriteReg  out  1  register file write enable (registered)
- DstReg  out  4  register file write address (registered)
- DstData  out  16  register file write data (registered)
- pending  out  16  bit i = a write to register i is in the FIFO or the output stage
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky; set when b_valid arrives with the FIFO full

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - WriteReg=0, DstReg=0, DstData=0.
  - FIFO empty; fifo_count=0; pending=0.
  - Starve counter=0; overflow=0.
  - rst has priority over all inputs. Mid-operation reset discards buffered writes.
- FIFO push: when b_valid=1, push {b_reg, b_data} at posedge.
  - Full and no pop in the same cycle: drop the entry and set overflow.
  - Full with a pop in the same cycle: the push succeeds.
- Arbitration, evaluated each cycle, combinational on current state. Signals:
  - fifo_ne: FIFO non-empty.
  - starve: counter >= STARVE_LIMIT.
  - a_conflict: a_reg matches the reg of any valid FIFO entry, or b_valid=1 and b_reg==a_reg.
  - Grant B (pop head) if fifo_ne and (!a_valid or starve or a_conflict).
  - Else grant A if a_valid and !a_conflict. In that case a_ready=1.
  - a_ready=0 whenever A is not granted, so A holds its request stable.
- Ordering: a_conflict forces older load writes to a register to drain before a younger writeback to that register. Writes to one register leave the port in arrival order.
- Starve counter:
  - Increments when fifo_ne and A wins.
  - Clears when B wins or the FIFO is empty.
  - Saturates at 15.
- Output stage, 1-cycle latency from grant:
  - The granted entry loads into DstReg/DstData next cycle, with WriteReg=1.
  - If nothing is granted, WriteReg=0 and DstReg/DstData hold.
  - With DROP_R0=1 and granted reg==0: WriteReg=0 (the entry is still consumed).
- pending: OR of one-hot decodes of every valid FIFO entry's reg and of DstReg when WriteReg=1.
  - A push appears in pending the cycle after b_valid.
- Simultaneous events:
  - Push and pop in the same cycle: fifo_count unchanged.
  - Pushing into an empty FIFO is not visible to arbitration until the next cycle (no bypass).
- Throughput: one write per cycle maximum; no bubbles while any requester is eligible.

Decomposition:
- Shared package (cpu_pkg):
  - REG_ID_W=4, DATA_W=16, NUM_REGS=16.
  - Typedef wr_req_t {reg_id, data}.
- One sub-module: wr_fifo (parameterised depth, push/pop/count/full/empty, plus an all-entries reg-id vector for the conflict/pending compare).
- Arbitration and the output register stay in the top module.

Test Plan:
- Reset:
  - Drive a_valid=1 and b_valid=1 with rst=1 for 2 cycles.
  - Required: WriteReg=0, pending=0, fifo_count=0, overflow=0, a_ready=0 throughout.
  - First posedge after rst=0: no residual write.
- A only:
  - a_valid=1, a_reg=5, a_data=16'h1234.
  - Required: a_ready=1 the same cycle; next cycle WriteReg=1, DstReg=5, DstData=16'h1234, pending[5]=1.
- Starvation:
  - b_valid one cycle (reg 3, data 16'hBEEF), then a_valid continuously to reg 7.
  - Required: A wins 3 cycles; 4th cycle a_ready=0 and B's entry writes reg 3 = 16'hBEEF next cycle.
- WAW conflict:
  - Push B reg 4 = 16'h0001, then a_valid reg 4 = 16'h0002.
  - Required: a_ready=0 until the FIFO entry pops.
  - Port order: reg4=0001, then reg4=0002.
- Overflow:
  - 5 consecutive b_valid with a_valid held on a non-conflicting register and STARVE_LIMIT=15, so the FIFO is not drained.
  - Required: fifo_count reaches 4, overflow=1 on the 5th push, and it remains 1 until reset.
- R0 drop:
  - a_valid reg 0 = 16'hFFFF.
  - Required: a_ready=1; next cycle WriteReg=0, pending[0]=0.
